seq_monitor: RTL and testbench

Checker stage that sits directly downstream of the 3-bit special sequence counter (cycle 0→5→6→2→7→0). It samples the counter's `q` every clock and verifies that each new value is the legal successor of the previous one. It reports lock status, counts completed sequence periods, and flags and counts faults for the board-level display and LED logic.

---
 rtl/seq_monitor.sv | 165 ++++++++++++++++
 tb/tb_seq_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_monitor.sv
// seq_monitor: checks that the 3-bit special sequence counter (0->5->6->2->7->0)
// advances legally. Holds are tolerated (enable-gated counter). It reports
// lock status, counts completed periods while locked, and flags/counts faults.
//
// Parameters:
//   LOCK_CNT  consecutive legal advances needed to declare lock (1..15)
//   CYC_W     width of period_cnt
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   q           counter value under test, sampled every edge
//   clr         synchronous clear of fault, counters and lock state
//   locked      sequence verified and tracking
//   fault       illegal value/transition seen while locked
//   period_cnt  completed 7->0 wraps seen while locked (modulo 2^CYC_W)
//   err_cnt     number of faults, saturating at 15
// Build option:
//   SEQ_MON_STICKY_FAULT_EN  when defined, FAULT is held until clr;
//                            otherwise fault is a one-cycle pulse and the
//                            monitor re-hunts automatically.
module seq_monitor #(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned CYC_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       q,
  input  logic             clr,
  output logic             locked,
  output logic             fault,
  output logic [CYC_W-1:0] period_cnt,
  output logic [3:0]       err_cnt
);

  localparam int unsigned Q_W   = 3;
  localparam int unsigned RUN_W = 4;
  localparam int unsigned ERR_W = 4;

  localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [Q_W-1:0]     q_d;
  logic [RUN_W-1:0]   run, run_n, run_inc;
  logic [CYC_W-1:0]   period_n;
  logic [ERR_W-1:0]   err_n;
  logic               locked_n, fault_n;
  logic               is_adv, is_hold, is_wrap;

  // Membership in the legal code set {0,5,6,2,7}
  function automatic logic code_legal(input logic [Q_W-1:0] v);
    case (v)
      3'd0, 3'd5, 3'd6, 3'd2, 3'd7: code_legal = 1'b1;
      default:                      code_legal = 1'b0;
    endcase
  endfunction

  // Expected next code of the counter
  function automatic logic [Q_W-1:0] code_succ(input logic [Q_W-1:0] v);
    case (v)
      3'd0:    code_succ = 3'd5;
      3'd5:    code_succ = 3'd6;
      3'd6:    code_succ = 3'd2;
      3'd2:    code_succ = 3'd7;
      3'd7:    code_succ = 3'd0;
      default: code_succ = 3'd0;
    endcase
  endfunction

  // Transition classification of the current sample against the previous one
  always_comb begin
    is_adv  = code_legal(q_d) && code_legal(q) && (q == code_succ(q_d));
    is_hold = code_legal(q) && (q == q_d);
    is_wrap = is_adv && (q_d == 3'd7);
    run_inc = run + RUN_W'(1);
  end

  // Next-state and next-output logic; clr overrides every other event
  always_comb begin
    state_n  = state;
    run_n    = run;
    period_n = period_cnt;
    err_n    = err_cnt;

    if (clr) begin
      state_n  = ST_HUNT;
      run_n    = '0;
      period_n = '0;
      err_n    = '0;
    end else begin
      case (state)
        ST_INIT: begin
          state_n = ST_HUNT;
          run_n   = '0;
        end
        ST_HUNT: begin
          if (is_adv) begin
            if (run_inc == LOCK_TGT) begin
              state_n = ST_LOCKED;
              run_n   = '0;
            end else begin
              run_n = run_inc;
            end
          end else if (!is_hold) begin
            run_n = '0;
          end
        end
        ST_LOCKED: begin
          if (is_adv || is_hold) begin
            if (is_wrap) period_n = period_cnt + CYC_W'(1);
          end else begin
            state_n = ST_FAULT;
            if (err_cnt != ERR_MAX) err_n = err_cnt + ERR_W'(1);
          end
        end
        ST_FAULT: begin
`ifdef SEQ_MON_STICKY_FAULT_EN
          // Held until clr; q is ignored apart from q_d sampling
          state_n = ST_FAULT;
`else
          // One-cycle fault pulse, then re-hunt from scratch
          state_n = ST_HUNT;
          run_n   = '0;
`endif
        end
        default: begin
          state_n = ST_INIT;
          run_n   = '0;
        end
      endcase
    end

    locked_n = (state_n == ST_LOCKED);
    fault_n  = (state_n == ST_FAULT);
  end

  // State, sample history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      q_d        <= '0;
      run        <= '0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      period_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      q_d        <= q;
      run        <= run_n;
      locked     <= locked_n;
      fault      <= fault_n;
      period_cnt <= period_n;
      err_cnt    <= err_n;
    end
  end

endmodule

// File: tb/tb_seq_monitor.sv
// Directed self-checking bench for seq_monitor. Three instances share the
// stimulus: default parameters, LOCK_CNT=1, and CYC_W=2.
module tb_seq_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] q = 3'd0;
  logic       clr = 1'b0;

  logic       locked, fault;
  logic [7:0] period_cnt;
  logic [3:0] err_cnt;

  logic       locked_l1, fault_l1;
  logic [7:0] period_l1;
  logic [3:0] err_l1;

  logic       locked_w, fault_w;
  logic [1:0] period_w;
  logic [3:0] err_w;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_err = 4'd0;
  logic [7:0] exp_per = 8'd0;

  always #5 clk = ~clk;

  seq_monitor dut (
    .clk(clk), .rst_n(rst_n), .q(q), .clr(clr),
    .locked(locked), .fault(fault), .period_cnt(period_cnt), .err_cnt(err_cnt)
  );

  seq_monitor #(.LOCK_CNT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .q(q), .clr(clr),
    .locked(locked_l1), .fault(fault_l1), .period_cnt(period_l1), .err_cnt(err_l1)
  );

  seq_monitor #(.CYC_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .q(q), .clr(clr),
    .locked(locked_w), .fault(fault_w), .period_cnt(period_w), .err_cnt(err_w)
  );

  // Drive one sample, let the edge take it, settle 1 time unit past the edge
  task automatic step(input logic [2:0] v, input logic c);
    q   = v;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse between edges (called 1 unit after a rising edge)
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    if (locked !== 1'b0) begin n_err++; $display("FAIL reset locked got %b want 0", locked); end
    n_vec++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset fault got %b want 0", fault); end
    n_vec++;
    if (period_cnt !== 8'd0) begin n_err++; $display("FAIL reset period_cnt got %0d want 0", period_cnt); end
    n_vec++;
    if (err_cnt !== 4'd0) begin n_err++; $display("FAIL reset err_cnt got %0d want 0", err_cnt); end
    n_vec++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    logic [2:0] qv [7] = '{3'd0, 3'd5, 3'd6, 3'd2, 3'd7, 3'd0, 3'd5};
    logic       lk [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       l1 [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] pc [7] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    for (int i = 0; i < 7; i++) begin
      step(qv[i], 1'b0);
      if (locked !== lk[i]) begin n_err++; $display("FAIL clean_lock locked edge %0d got %b want %b", i+1, locked, lk[i]); end
      n_vec++;
      if (locked_l1 !== l1[i]) begin n_err++; $display("FAIL clean_lock locked_l1 edge %0d got %b want %b", i+1, locked_l1, l1[i]); end
      n_vec++;
      if (period_cnt !== pc[i]) begin n_err++; $display("FAIL clean_lock period_cnt edge %0d got %0d want %0d", i+1, period_cnt, pc[i]); end
      n_vec++;
      if (fault !== 1'b0) begin n_err++; $display("FAIL clean_lock fault edge %0d got %b want 0", i+1, fault); end
      n_vec++;
    end
    exp_per = 8'd1;
  endtask

  task automatic test_invalid_code();
    step(3'd3, 1'b0);
    exp_err = 4'd1;
    if (fault !== 1'b1) begin n_err++; $display("FAIL invalid fault got %b want 1", fault); end
    n_vec++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL invalid locked got %b want 0", locked); end
    n_vec++;
    if (err_cnt !== exp_err) begin n_err++; $display("FAIL invalid err_cnt got %0d want %0d", err_cnt, exp_err); end
    n_vec++;
`ifdef SEQ_MON_STICKY_FAULT_EN
    begin
      logic [2:0] hv [5] = '{3'd5, 3'd6, 3'd2, 3'd7, 3'd0};
      for (int i = 0; i < 5; i++) begin
        step(hv[i], 1'b0);
        if (fault !== 1'b1) begin n_err++; $display("FAIL sticky_hold fault step %0d got %b want 1", i, fault); end
        n_vec++;
        if (locked !== 1'b0) begin n_err++; $display("FAIL sticky_hold locked step %0d got %b want 0", i, locked); end
        n_vec++;
      end
    end
    step(3'd5, 1'b1);
    exp_err = 4'd0;
    exp_per = 8'd0;
    if (err_cnt !== 4'd0) begin n_err++; $display("FAIL sticky_clr err_cnt got %0d want 0", err_cnt); end
    n_vec++;
`else
    step(3'd5, 1'b0);
`endif
    if (fault !== 1'b0) begin n_err++; $display("FAIL invalid_recover fault got %b want 0", fault); end
    n_vec++;
    step(3'd6, 1'b0);
    if (locked !== 1'b0) begin n_err++; $display("FAIL invalid_recover locked early got %b want 0", locked); end
    n_vec++;
    step(3'd2, 1'b0);
    if (locked !== 1'b1) begin n_err++; $display("FAIL invalid_relock locked got %b want 1", locked); end
    n_vec++;
    if (period_cnt !== exp_per) begin n_err++; $display("FAIL invalid_relock period_cnt got %0d want %0d", period_cnt, exp_per); end
    n_vec++;
  endtask

  // Includes a 6,6 hold while locked, then 5 followed by 2
  task automatic test_illegal_transition();
    logic [2:0] qv [10] = '{3'd7, 3'd0, 3'd5, 3'd6, 3'd6, 3'd2, 3'd7, 3'd0, 3'd5, 3'd2};
    for (int i = 0; i < 10; i++) begin
      step(qv[i], 1'b0);
      if (fault !== (i == 9)) begin n_err++; $display("FAIL illegal_trans fault step %0d got %b want %b", i, fault, (i == 9)); end
      n_vec++;
      if (locked !== (i != 9)) begin n_err++; $display("FAIL illegal_trans locked step %0d got %b want %b", i, locked, (i != 9)); end
      n_vec++;
    end
    exp_err = exp_err + 4'd1;
    exp_per = exp_per + 8'd2;
    if (err_cnt !== exp_err) begin n_err++; $display("FAIL illegal_trans err_cnt got %0d want %0d", err_cnt, exp_err); end
    n_vec++;
    if (period_cnt !== exp_per) begin n_err++; $display("FAIL illegal_trans period_cnt got %0d want %0d", period_cnt, exp_per); end
    n_vec++;
  endtask

  task automatic test_saturation();
`ifndef SEQ_MON_STICKY_FAULT_EN
    logic [3:0] want;
    step(3'd0, 1'b0);
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      step(3'd0, 1'b0);
      step(3'd5, 1'b0);
      step(3'd6, 1'b0);
      if (locked !== 1'b1) begin n_err++; $display("FAIL sat_relock locked iter %0d got %b want 1", i, locked); end
      n_vec++;
      step(3'd3, 1'b0);
      want = (i >= 14) ? 4'd15 : 4'(i + 1);
      if (err_cnt !== want) begin n_err++; $display("FAIL sat err_cnt iter %0d got %0d want %0d", i, err_cnt, want); end
      n_vec++;
    end
`endif
  endtask

  task automatic test_period_wrap();
    logic [2:0] pv [5] = '{3'd5, 3'd6, 3'd2, 3'd7, 3'd0};
    apply_reset();
    step(3'd0, 1'b0);
    step(3'd5, 1'b0);
    step(3'd6, 1'b0);
    step(3'd2, 1'b0);
    step(3'd7, 1'b0);
    step(3'd0, 1'b0);
    if (period_w !== 2'd1) begin n_err++; $display("FAIL wrap period_w first got %0d want 1", period_w); end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) step(pv[j], 1'b0);
      if (period_w !== 2'(k + 2)) begin n_err++; $display("FAIL wrap period_w period %0d got %0d want %0d", k+2, period_w, 2'(k + 2)); end
      n_vec++;
      if (period_cnt !== 8'(k + 2)) begin n_err++; $display("FAIL wrap period_cnt period %0d got %0d want %0d", k+2, period_cnt, k+2); end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pv [5] = '{3'd2, 3'd7, 3'd0, 3'd5, 3'd6};
    logic [3:0] want_err;
    apply_reset();
`ifndef SEQ_MON_STICKY_FAULT_EN
    for (int i = 0; i < 2; i++) begin
      step(3'd0, 1'b0);
      step(3'd5, 1'b0);
      step(3'd6, 1'b0);
      step(3'd3, 1'b0);
    end
    want_err = 4'd2;
`else
    want_err = 4'd0;
`endif
    step(3'd0, 1'b0);
    step(3'd5, 1'b0);
    step(3'd6, 1'b0);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 5; j++) step(pv[j], 1'b0);
    if (locked !== 1'b1) begin n_err++; $display("FAIL rst_mid pre locked got %b want 1", locked); end
    n_vec++;
    if (period_cnt !== 8'd3) begin n_err++; $display("FAIL rst_mid pre period_cnt got %0d want 3", period_cnt); end
    n_vec++;
    if (err_cnt !== want_err) begin n_err++; $display("FAIL rst_mid pre err_cnt got %0d want %0d", err_cnt, want_err); end
    n_vec++;
    rst_n = 1'b0;
    #2;
    if (locked !== 1'b0) begin n_err++; $display("FAIL rst_mid locked got %b want 0", locked); end
    n_vec++;
    if (period_cnt !== 8'd0) begin n_err++; $display("FAIL rst_mid period_cnt got %0d want 0", period_cnt); end
    n_vec++;
    if (err_cnt !== 4'd0) begin n_err++; $display("FAIL rst_mid err_cnt got %0d want 0", err_cnt); end
    n_vec++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL rst_mid fault got %b want 0", fault); end
    n_vec++;
    #1 rst_n = 1'b1;
    step(3'd0, 1'b0);
    if (locked !== 1'b0) begin n_err++; $display("FAIL rst_mid relock edge1 got %b want 0", locked); end
    n_vec++;
    step(3'd5, 1'b0);
    if (locked !== 1'b0) begin n_err++; $display("FAIL rst_mid relock edge2 got %b want 0", locked); end
    n_vec++;
    step(3'd6, 1'b0);
    if (locked !== 1'b1) begin n_err++; $display("FAIL rst_mid relock edge3 got %b want 1", locked); end
    n_vec++;
  endtask

  task automatic test_clr_priority();
    step(3'd2, 1'b0);
    step(3'd7, 1'b0);
    step(3'd0, 1'b0);
    if (period_cnt !== 8'd1) begin n_err++; $display("FAIL clr_prio pre period_cnt got %0d want 1", period_cnt); end
    n_vec++;
    step(3'd3, 1'b1);
    if (fault !== 1'b0) begin n_err++; $display("FAIL clr_prio fault got %b want 0", fault); end
    n_vec++;
    if (err_cnt !== 4'd0) begin n_err++; $display("FAIL clr_prio err_cnt got %0d want 0", err_cnt); end
    n_vec++;
    if (period_cnt !== 8'd0) begin n_err++; $display("FAIL clr_prio period_cnt got %0d want 0", period_cnt); end
    n_vec++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL clr_prio locked got %b want 0", locked); end
    n_vec++;
    step(3'd5, 1'b0);
    if (fault !== 1'b0) begin n_err++; $display("FAIL clr_prio post fault got %b want 0", fault); end
    n_vec++;
    step(3'd6, 1'b0);
    step(3'd2, 1'b0);
    if (locked !== 1'b1) begin n_err++; $display("FAIL clr_prio relock got %b want 1", locked); end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_invalid_code();
    test_illegal_transition();
    test_saturation();
    test_period_wrap();
    test_reset_mid();
    test_clr_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
